// File: rtl/uart_tx_sequencer.sv
// UART transmit frame sequencer.
// Accepts one byte over a valid/ready handshake and latches it together with
// the line configuration. It then shifts out start, eight data bits (LSB
// first), an optional parity bit and one or two stop bits. Each bit lasts
// CLKS_PER_BIT clocks. The parity value comes from an external parity unit
// that watches frame_data/frame_parity_type. All outputs except tx_ready are
// registered, and the registered ones are computed from next-state values.
module uart_tx_sequencer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  input  logic       parity_bit,
  output logic       tx_ready,
  output logic [7:0] frame_data,
  output logic [1:0] frame_parity_type,
  output logic       tx_serial,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0]  ST_IDLE   = 3'd0;
  localparam logic [2:0]  ST_START  = 3'd1;
  localparam logic [2:0]  ST_DATA   = 3'd2;
  localparam logic [2:0]  ST_PARITY = 3'd3;
  localparam logic [2:0]  ST_STOP   = 3'd4;
  localparam logic [15:0] CNT_MAX   = 16'(CLKS_PER_BIT - 1);

  // A parity slot exists only for the odd (01) and even (10) modes.
  function automatic logic parity_enabled(input logic [1:0] pt);
    return (pt == 2'b01) || (pt == 2'b10);
  endfunction

  logic [2:0]  state_r;
  logic [15:0] cnt_r;
  logic [2:0]  bit_idx_r;
  logic        stop_idx_r;
  logic        stop2_r;
  logic [7:0]  frame_data_r;
  logic [1:0]  frame_pt_r;
  logic        tx_serial_r;
  logic        busy_r;
  logic        done_r;

  logic [2:0]  state_s;
  logic [15:0] cnt_s;
  logic [2:0]  bit_idx_s;
  logic        stop_idx_s;
  logic        bit_end_s;
  logic        last_stop_s;
  logic        tx_ready_s;
  logic        accept_s;
  logic        tx_serial_s;
  logic        busy_s;
  logic        done_s;

  assign bit_end_s   = (cnt_r == CNT_MAX);
  assign last_stop_s = (stop_idx_r == stop2_r);
  // Ready also covers the final stop cycle, so frames can run back-to-back.
  assign tx_ready_s  = reset_n && ((state_r == ST_IDLE) ||
                                   ((state_r == ST_STOP) && bit_end_s && last_stop_s));
  assign accept_s    = tx_valid && tx_ready_s;

  // Next-state, bit counter and bit/stop index computation.
  always_comb begin
    state_s    = state_r;
    bit_idx_s  = bit_idx_r;
    stop_idx_s = stop_idx_r;
    if (state_r == ST_IDLE) begin
      cnt_s = 16'd0;
    end else if (bit_end_s) begin
      cnt_s = 16'd0;
    end else begin
      cnt_s = cnt_r + 16'd1;
    end
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_s   = ST_DATA;
          bit_idx_s = 3'd0;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s && (bit_idx_r != 3'd7)) begin
          bit_idx_s = bit_idx_r + 3'd1;
        end else if (bit_end_s) begin
          stop_idx_s = 1'b0;
          if (parity_enabled(frame_pt_r)) begin
            state_s = ST_PARITY;
          end else begin
            state_s = ST_STOP;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_s    = ST_STOP;
          stop_idx_s = 1'b0;
        end else begin
          state_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_end_s && !last_stop_s) begin
          stop_idx_s = 1'b1;
        end else if (bit_end_s && accept_s) begin
          state_s = ST_START;
        end else if (bit_end_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        cnt_s      = 16'd0;
        bit_idx_s  = 3'd0;
        stop_idx_s = 1'b0;
      end
    endcase
  end

  // Registered-output values derived from the next state, so outputs change cleanly at the edge.
  always_comb begin
    case (state_s)
      ST_IDLE:   tx_serial_s = 1'b1;
      ST_START:  tx_serial_s = 1'b0;
      ST_DATA:   tx_serial_s = frame_data_r[bit_idx_s];
      ST_PARITY: tx_serial_s = parity_bit;
      ST_STOP:   tx_serial_s = 1'b1;
      default:   tx_serial_s = 1'b1;
    endcase
    busy_s = (state_s != ST_IDLE);
    done_s = (state_s == ST_STOP) && (cnt_s == CNT_MAX) && (stop_idx_s == stop2_r);
  end

  // State, counters, latched frame configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 16'd0;
      bit_idx_r    <= 3'd0;
      stop_idx_r   <= 1'b0;
      stop2_r      <= 1'b0;
      frame_data_r <= 8'd0;
      frame_pt_r   <= 2'd0;
      tx_serial_r  <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      bit_idx_r   <= bit_idx_s;
      stop_idx_r  <= stop_idx_s;
      tx_serial_r <= tx_serial_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      if (accept_s) begin
        frame_data_r <= tx_data;
        frame_pt_r   <= parity_type;
        stop2_r      <= stop_bits;
      end else begin
        frame_data_r <= frame_data_r;
        frame_pt_r   <= frame_pt_r;
        stop2_r      <= stop2_r;
      end
    end
  end

  assign tx_ready          = tx_ready_s;
  assign frame_data        = frame_data_r;
  assign frame_parity_type = frame_pt_r;
  assign tx_serial         = tx_serial_r;
  assign busy              = busy_r;
  assign done              = done_r;

endmodule

// File: doc/uart_tx_sequencer.md
# uart_tx_sequencer

Frame sequencer for the UART transmitter. It accepts a byte over a valid/ready handshake and latches the byte and line configuration. It then drives the serial line through start, data (LSB first), optional parity and stop bits, timing each bit with an internal bit-period counter. It presents the latched byte and parity type to the parity unit and samples that unit's combinational `parity_bit` output during the parity slot.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal values are 2 to 65535.

Ports:
- `clk`, input, 1: system clock. All logic is rising-edge.
- `reset_n`, input, 1: reset, synchronous, active-low.
- `tx_valid`, input, 1: upstream has a byte to send.
- `tx_data`, input, 8: byte to send. Sampled at acceptance.
- `parity_type`, input, 2: line parity mode. 01 = odd, 10 = even, 00/11 = no parity slot. Sampled at acceptance.
- `stop_bits`, input, 1: 0 = one stop bit, 1 = two stop bits. Sampled at acceptance.
- `parity_bit`, input, 1: from the parity unit. Computed from `frame_data`/`frame_parity_type`.
- `tx_ready`, output, 1: sequencer can accept a byte this cycle.
- `frame_data`, output, 8: latched byte. Feeds the parity unit `data_in`.
- `frame_parity_type`, output, 2: latched parity mode. Feeds the parity unit `parity_type`.
- `tx_serial`, output, 1: serial line. Idle high.
- `busy`, output, 1: a frame is in progress.
- `done`, output, 1: one-cycle pulse in the final cycle of the last stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- The bit counter `cnt` counts 0..CLKS_PER_BIT-1 within each bit. `bit_end` = (cnt == CLKS_PER_BIT-1).
- `bit_idx` (3 bits) counts data bits. `stop_idx` (1 bit) counts stop bits.
- Acceptance: `tx_valid && tx_ready` at a rising edge.
  - On acceptance, latch `tx_data`, `parity_type` and `stop_bits`.
  - Go to START with `cnt`=0.
  - Inputs are ignored at all other times.
- `tx_ready` = `reset_n` && (state==IDLE || (state==STOP && bit_end && last stop bit)). It is combinational from registered state.
- IDLE: `tx_serial`=1, `busy`=0.
- START: `tx_serial`=0. On `bit_end`, go to DATA with `bit_idx`=0.
- DATA: `tx_serial`=`frame_data[bit_idx]`.
  - On `bit_end` with `bit_idx`<7, increment `bit_idx`.
  - On `bit_end` with `bit_idx`==7, go to PARITY if the mode is 01/10, else go to STOP.
- PARITY: `tx_serial`=`parity_bit`, sampled every cycle. On `bit_end`, go to STOP with `stop_idx`=0.
- STOP: `tx_serial`=1.
  - On `bit_end` and not the last stop bit, increment `stop_idx`.
  - On `bit_end` and the last stop bit, assert `done`. Go to START if a new byte is accepted in that cycle, else go to IDLE.
- `busy`=1 in every state except IDLE.
- `frame_data` and `frame_parity_type` hold their values until the next acceptance. The parity input is stable for the whole frame.
- `tx_serial` is registered. It is glitch-free and derived from next-state/next-index.

## Timing
- Let T0 be the accepting edge. `tx_serial` falls to 0 in the cycle after T0. `busy` rises in the same cycle.
- Each bit lasts exactly CLKS_PER_BIT cycles. Frame length is CLKS_PER_BIT × (9 + P + S) cycles, where P ∈ {0,1} and S ∈ {1,2}.
- Data bit i occupies cycles T0+1+(1+i)·N through T0+(2+i)·N, where N = CLKS_PER_BIT.
- `done` is high in the final frame cycle only.
- Back-to-back: acceptance in the `done` cycle starts the next start bit in the following cycle. There is no idle gap.
- Reset values, at the first edge with `reset_n`=0:
  - state IDLE, `tx_serial`=1, `busy`=0, `done`=0.
  - `frame_data`=0, `frame_parity_type`=0, counters 0.
  - `tx_ready`=0 while `reset_n` is low.
- Reset mid-frame aborts the frame. The line returns high at the next edge and no `done` pulse is produced.
- `tx_valid` held high with changing `tx_data` mid-frame has no effect on the frame in flight.

## Test plan
- N=4, byte 0xA5, mode 00, one stop bit, accepted at T0 → line 0,1,0,1,0,0,1,0,1,1 over 10 bits, each exactly 4 cycles. `done` pulses at T0+40. `busy` low at T0+41.
- N=4, 0x07, odd mode (parity unit attached) → parity slot =0. Even mode → parity slot =1. Frame is 44 cycles.
- N=4, 0x00, even mode, two stop bits → parity slot 0, then 2 stop bits. `done` pulses at T0+48.
- N=4, `tx_valid` held high with 0x55 then 0x0F, one stop, no parity → second start bit begins the cycle after the first `done`. No high gap between the frames beyond the stop bit.
- `reset_n` low during data bit 3, then released → `tx_serial`=1 and `busy`=0 at the next edge, and no `done` pulse. `tx_ready`=1 after release, and a new frame then transmits correctly.
- Change `tx_data`/`parity_type` mid-frame → transmitted bits and the parity slot still match the values latched at T0.
